z80_io_bridge: RTL and testbench

- Upstream stage feeding the VDP CPU port (REQ/WRT/ADR/DBO/DBI).
- Takes raw Z80 I/O strobes (csr_n, csw_n, decoded from A7..A2/iorq_n/rd_n/wr_n) plus the mode[1:0] port select and data bus.
- Synchronises and glitch-filters the strobes, then issues exactly one single-cycle request per bus cycle with latched address/data.
- For reads, captures VDP read data after a fixed latency and holds it for the cd tristate driver until the strobe releases.

---
 rtl/z80_io_bridge.sv | 209 ++++++++++++++++++++
 tb/tb_z80_io_bridge.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_io_bridge.sv
// z80_io_bridge
//   Front end between raw Z80 I/O strobes and the VDP CPU port. The chip
//   selects are synchronised and glitch-filtered. A small FSM then issues
//   exactly one single-cycle request per Z80 bus cycle, with the port select
//   and write data latched. For reads, VDP data is captured RD_LAT cycles
//   after the request and is held for the Z80 bus driver until the read
//   strobe releases.
//
// Parameters
//   FILTER_LEN  identical synchronised samples needed to move a filtered strobe (1..15)
//   RD_LAT      clk cycles from req to capture of dbi (1..7)
//
// Ports
//   clk        27 MHz pixel/VDP clock
//   reset      synchronous, active-high
//   csr_n      raw chip-select-read, active-low, asynchronous
//   csw_n      raw chip-select-write, active-low, asynchronous
//   mode       raw port select, sampled only at the request edge
//   cd_in      raw Z80 data bus, sampled only at the request edge
//   req        single-cycle request to the VDP
//   wrt        1 = write, valid only while req = 1
//   adr        latched port select
//   dbo        latched write data
//   dbi        VDP read data
//   cd_out     read data for the Z80 bus driver (holds when cd_oe = 0)
//   cd_oe      drive enable for cd_out
//   collision  single-cycle pulse when both strobes go active together

module z80_io_bridge #(
  parameter int unsigned FILTER_LEN = 3,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       csr_n,
  input  logic       csw_n,
  input  logic [1:0] mode,
  input  logic [7:0] cd_in,
  output logic       req,
  output logic       wrt,
  output logic [1:0] adr,
  output logic [7:0] dbo,
  input  logic [7:0] dbi,
  output logic [7:0] cd_out,
  output logic       cd_oe,
  output logic       collision
);

  typedef enum logic [1:0] {
    IDLE,
    RDWAIT,
    HOLD
  } state_t;

  localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [2:0] LAT_LOAD  = 3'(RD_LAT - 1);

  // Index 0 = read strobe, index 1 = write strobe.
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] filt;
  logic [3:0] filt_cnt [2];

  logic fr_n;
  logic fw_n;

  assign fr_n = filt[0];
  assign fw_n = filt[1];

  // --------------------------------------------------------------------------
  // Synchroniser and glitch filter
  // --------------------------------------------------------------------------
  // The filtered value only moves after FILTER_LEN consecutive samples that
  // disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before the edge, whatever the statement order.
    if (reset) begin
      sync1       <= 2'b11;
      sync2       <= 2'b11;
      filt        <= 2'b11;
      filt_cnt[0] <= '0;
      filt_cnt[1] <= '0;
    end else begin
      sync1 <= {csw_n, csr_n};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FILT_LAST) begin
          filt[i]     <= sync2[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 4'd1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Bus-cycle FSM
  // --------------------------------------------------------------------------
  state_t     state,     state_nx;
  logic [2:0] lat_cnt,   lat_cnt_nx;
  logic       req_nx;
  logic       wrt_nx;
  logic [1:0] adr_nx;
  logic [7:0] dbo_nx;
  logic [7:0] cd_out_nx;
  logic       cd_oe_nx;
  logic       collision_nx;

  always_comb begin
    // NOTE: every output gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_nx     = state;
    lat_cnt_nx   = lat_cnt;
    req_nx       = 1'b0;
    wrt_nx       = 1'b0;
    adr_nx       = adr;
    dbo_nx       = dbo;
    cd_out_nx    = cd_out;
    cd_oe_nx     = cd_oe;
    collision_nx = 1'b0;

    unique case (state)
      IDLE: begin
        cd_oe_nx = 1'b0;
        unique case ({fr_n, fw_n})
          2'b10: begin
            req_nx   = 1'b1;
            wrt_nx   = 1'b1;
            adr_nx   = mode;
            dbo_nx   = cd_in;
            state_nx = HOLD;
          end
          2'b01: begin
            req_nx     = 1'b1;
            adr_nx     = mode;
            lat_cnt_nx = LAT_LOAD;
            state_nx   = RDWAIT;
          end
          2'b00: begin
            // Both strobes qualified on the same edge: flag it. Do not
            // guess a direction.
            collision_nx = 1'b1;
            state_nx     = HOLD;
          end
          default: ;
        endcase
      end

      RDWAIT: begin
        cd_oe_nx = 1'b0;
        if (fr_n) begin
          // Z80 gave up on the read before the data arrived.
          state_nx = HOLD;
        end else if (lat_cnt == 3'd0) begin
          cd_out_nx = dbi;
          cd_oe_nx  = 1'b1;
          state_nx  = HOLD;
        end else begin
          lat_cnt_nx = lat_cnt - 3'd1;
        end
      end

      HOLD: begin
        if (fr_n) begin
          cd_oe_nx = 1'b0;
        end
        // Both strobes must release before a new access can start, so a
        // strobe changing type while held does not produce a second request.
        if (fr_n && fw_n) begin
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
        cd_oe_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      req       <= 1'b0;
      wrt       <= 1'b0;
      adr       <= '0;
      dbo       <= '0;
      cd_out    <= '0;
      cd_oe     <= 1'b0;
      collision <= 1'b0;
    end else begin
      state     <= state_nx;
      lat_cnt   <= lat_cnt_nx;
      req       <= req_nx;
      wrt       <= wrt_nx;
      adr       <= adr_nx;
      dbo       <= dbo_nx;
      cd_out    <= cd_out_nx;
      cd_oe     <= cd_oe_nx;
      collision <= collision_nx;
    end
  end

endmodule

// File: tb/tb_z80_io_bridge.sv
// tb_z80_io_bridge
//   Directed bench for z80_io_bridge. Two instances share all inputs:
//     u_dut  FILTER_LEN=3, RD_LAT=2 (main checks, scoreboarded)
//     u_slow FILTER_LEN=3, RD_LAT=7 (read-abort case)
//   Expected requests and collision pulses are pushed to queues when the
//   stimulus is driven. A negedge monitor pops and compares them in the cycle
//   they are due, and flags any request or pulse that nothing predicted.
//   Inputs are driven and outputs sampled on the falling edge.

module tb_z80_io_bridge;

  localparam int FL = 3;
  // Cycles from driving a strobe low (on a falling edge) to seeing req.
  localparam int REQ_DLY = FL + 3;

  typedef struct {
    logic       wrt;
    logic [1:0] adr;
    logic [7:0] dbo;
    int         cyc;
  } req_exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       csr_n;
  logic       csw_n;
  logic [1:0] mode;
  logic [7:0] cd_in;
  logic [7:0] dbi;

  logic       req,  req2;
  logic       wrt,  wrt2;
  logic [1:0] adr,  adr2;
  logic [7:0] dbo,  dbo2;
  logic [7:0] cd_out, cd_out2;
  logic       cd_oe,  cd_oe2;
  logic       collision, collision2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int req2_cnt = 0;
  int oe2_cnt  = 0;

  req_exp_t req_q [$];
  int       col_q [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  z80_io_bridge #(.FILTER_LEN(FL), .RD_LAT(2)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .csr_n     (csr_n),
    .csw_n     (csw_n),
    .mode      (mode),
    .cd_in     (cd_in),
    .req       (req),
    .wrt       (wrt),
    .adr       (adr),
    .dbo       (dbo),
    .dbi       (dbi),
    .cd_out    (cd_out),
    .cd_oe     (cd_oe),
    .collision (collision)
  );

  z80_io_bridge #(.FILTER_LEN(FL), .RD_LAT(7)) u_slow (
    .clk       (clk),
    .reset     (reset),
    .csr_n     (csr_n),
    .csw_n     (csw_n),
    .mode      (mode),
    .cd_in     (cd_in),
    .req       (req2),
    .wrt       (wrt2),
    .adr       (adr2),
    .dbo       (dbo2),
    .dbi       (dbi),
    .cd_out    (cd_out2),
    .cd_oe     (cd_oe2),
    .collision (collision2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic to_cycle(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push_req(input logic w, input logic [1:0] a, input logic [7:0] d, input int c);
    req_exp_t e;
    e.wrt = w;
    e.adr = a;
    e.dbo = d;
    e.cyc = c;
    req_q.push_back(e);
  endtask

  // Scoreboard monitor for the main instance.
  always @(negedge clk) begin
    if (req_q.size() > 0 && req_q[0].cyc == cyc) begin
      check("req_pulse", req, 1'b1);
      check("req_wrt",   wrt, req_q[0].wrt);
      check("req_adr",   adr, req_q[0].adr);
      check("req_dbo",   dbo, req_q[0].dbo);
      void'(req_q.pop_front());
    end else if (req !== 1'b0) begin
      check("spurious_req", req, 1'b0);
    end

    if (col_q.size() > 0 && col_q[0] == cyc) begin
      check("collision_pulse", collision, 1'b1);
      void'(col_q.pop_front());
    end else if (collision !== 1'b0) begin
      check("spurious_collision", collision, 1'b0);
    end
  end

  always @(negedge clk) begin
    if (req2 === 1'b1)   req2_cnt <= req2_cnt + 1;
    if (cd_oe2 === 1'b1) oe2_cnt  <= oe2_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int d2;
    int r;
    int req2_base;
    int oe2_base;

    reset = 1'b1;
    csr_n = 1'b1;
    csw_n = 1'b1;
    mode  = 2'b00;
    cd_in = 8'h00;
    dbi   = 8'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_req",       req,       1'b0);
    check("rst_wrt",       wrt,       1'b0);
    check("rst_adr",       adr,       2'b00);
    check("rst_dbo",       dbo,       8'h00);
    check("rst_cd_out",    cd_out,    8'h00);
    check("rst_cd_oe",     cd_oe,     1'b0);
    check("rst_collision", collision, 1'b0);
    reset = 1'b0;
    to_cycle(cyc + 4);

    // Write: one req with latched port/data, then a 2-cycle high gap that
    // must be merged into the same access.
    d     = cyc;
    mode  = 2'b01;
    cd_in = 8'hA5;
    csw_n = 1'b0;
    push_req(1'b1, 2'b01, 8'hA5, d + REQ_DLY);
    to_cycle(d + 10);
    check("wr_cd_oe_low", cd_oe, 1'b0);
    cd_in = 8'h5A;
    to_cycle(d + 20);
    csw_n = 1'b1;
    to_cycle(d + 22);
    csw_n = 1'b0;
    to_cycle(d + 32);
    csw_n = 1'b1;
    check("wr_dbo_held", dbo, 8'hA5);
    check("wr_cd_oe_end", cd_oe, 1'b0);
    r = cyc;

    // Read after the minimum legal high gap (FILTER_LEN+2).
    to_cycle(r + FL + 2);
    d     = cyc;
    mode  = 2'b00;
    cd_in = 8'h77;
    dbi   = 8'h3C;
    csr_n = 1'b0;
    push_req(1'b0, 2'b00, 8'hA5, d + REQ_DLY);
    to_cycle(d + REQ_DLY + 1);
    check("rd_oe_before_lat", cd_oe, 1'b0);
    to_cycle(d + REQ_DLY + 2);
    check("rd_oe_at_lat",  cd_oe,  1'b1);
    check("rd_cd_out",     cd_out, 8'h3C);
    to_cycle(d + 12);
    dbi = 8'hC3;
    check("rd_dbo_kept",   dbo,    8'hA5);
    check("rd_cd_out_held", cd_out, 8'h3C);
    to_cycle(d + 20);
    csr_n = 1'b1;
    to_cycle(d + 25);
    check("rd_oe_before_drop", cd_oe, 1'b1);
    to_cycle(d + 26);
    check("rd_oe_dropped",  cd_oe,  1'b0);
    check("rd_out_hold_off", cd_out, 8'h3C);

    // Glitches of 2 and 1 samples: never reach the FSM.
    to_cycle(cyc + 10);
    d     = cyc;
    csw_n = 1'b0;
    to_cycle(d + 2);
    csw_n = 1'b1;
    to_cycle(d + 10);
    csw_n = 1'b0;
    to_cycle(d + 11);
    csw_n = 1'b1;
    to_cycle(d + 20);
    check("glitch_dbo_unchanged", dbo, 8'hA5);

    // Collision, then a normal write is accepted again.
    d     = cyc;
    csr_n = 1'b0;
    csw_n = 1'b0;
    col_q.push_back(d + REQ_DLY);
    to_cycle(d + 10);
    csr_n = 1'b1;
    csw_n = 1'b1;
    check("col_cd_oe", cd_oe, 1'b0);
    to_cycle(d + 18);
    d2    = cyc;
    mode  = 2'b11;
    cd_in = 8'h96;
    csw_n = 1'b0;
    push_req(1'b1, 2'b11, 8'h96, d2 + REQ_DLY);
    to_cycle(d2 + 12);
    csw_n = 1'b1;
    to_cycle(d2 + 22);

    // Short read: RD_LAT=7 instance aborts, RD_LAT=2 instance still captures.
    req2_base = req2_cnt;
    oe2_base  = oe2_cnt;
    d     = cyc;
    mode  = 2'b10;
    dbi   = 8'h5A;
    csr_n = 1'b0;
    push_req(1'b0, 2'b10, 8'h96, d + REQ_DLY);
    to_cycle(d + FL + 3);
    csr_n = 1'b1;
    to_cycle(d + REQ_DLY + 2);
    check("short_rd_fast_oe",  cd_oe,  1'b1);
    check("short_rd_fast_out", cd_out, 8'h5A);
    to_cycle(d + 25);
    check("abort_req_count", req2_cnt - req2_base, 1);
    check("abort_no_oe",     oe2_cnt - oe2_base,   0);
    check("abort_fast_oe_off", cd_oe, 1'b0);

    // Reset while in RDWAIT, strobe still low afterwards.
    d     = cyc;
    mode  = 2'b10;
    dbi   = 8'hE7;
    csr_n = 1'b0;
    push_req(1'b0, 2'b10, 8'h96, d + REQ_DLY);
    to_cycle(d + REQ_DLY);
    reset = 1'b1;
    to_cycle(d + REQ_DLY + 1);
    check("mid_rst_req",       req,       1'b0);
    check("mid_rst_wrt",       wrt,       1'b0);
    check("mid_rst_adr",       adr,       2'b00);
    check("mid_rst_dbo",       dbo,       8'h00);
    check("mid_rst_cd_out",    cd_out,    8'h00);
    check("mid_rst_cd_oe",     cd_oe,     1'b0);
    check("mid_rst_collision", collision, 1'b0);
    to_cycle(d + REQ_DLY + 2);
    reset = 1'b0;
    r = cyc;
    push_req(1'b0, 2'b10, 8'h00, r + REQ_DLY);
    to_cycle(r + REQ_DLY + 2);
    check("post_rst_oe",  cd_oe,  1'b1);
    check("post_rst_out", cd_out, 8'hE7);
    csr_n = 1'b1;
    to_cycle(r + 25);
    check("post_rst_oe_off", cd_oe, 1'b0);

    check("req_queue_drained", req_q.size(), 0);
    check("col_queue_drained", col_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
